// File: rtl/ir_seq.sv
// ir_seq: byte-serial instruction register with fixed or opcode-encoded length.
// Holds a complete instruction until the decoder handshakes it away.
module ir_seq #(
  parameter int DATA_W   = 8,
  parameter int NBYTES   = 2,
  parameter int LEN_MODE = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         flush,
  input  logic                                         start,
  input  logic                                         byte_valid,
  input  logic [DATA_W-1:0]                            byte_data,
  output logic                                         byte_ready,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [DATA_W-1:0]                            opcode,
  output logic [(NBYTES > 1 ? NBYTES-1 : 1)*DATA_W-1:0] operand,
  output logic [2:0]                                   instr_len,
  output logic                                         busy
);
  localparam int OPW = (NBYTES > 1 ? NBYTES-1 : 1)*DATA_W;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_idx, r_len, w_dec, w_len0, w_cur_len;
  logic [DATA_W-1:0] r_opcode;
  logic [OPW-1:0]    r_operand;
  logic              w_accept, w_last, w_restart;
  // The opcode byte decides the length in the same cycle it is captured.
  always_comb begin
    w_accept  = r_state == FETCH && byte_valid;
    w_dec     = {1'b0, byte_data[1:0]} + 3'd1;
    w_len0    = (LEN_MODE == 0 || w_dec > 3'(NBYTES)) ? 3'(NBYTES) : w_dec;
    w_cur_len = r_idx == 3'd0 ? w_len0 : r_len;
    w_last    = w_accept && r_idx == w_cur_len - 3'd1;
    w_restart = start && (r_state == IDLE || (r_state == HOLD && out_ready));
    w_next    = r_state == IDLE  ? (start ? FETCH : IDLE) :
                r_state == FETCH ? (w_last ? HOLD : FETCH) :
                (out_ready ? (start ? FETCH : IDLE) : HOLD);
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state   <= IDLE;
      r_idx     <= 3'd0;
      r_len     <= 3'(NBYTES);
      r_opcode  <= '0;
      r_operand <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_idx     <= 3'd0;
        r_len     <= 3'(NBYTES);
        r_opcode  <= '0;
        r_operand <= '0;
      end else if (w_accept) begin
        r_idx <= r_idx + 3'd1;
        if (r_idx == 3'd0) begin
          r_opcode <= byte_data;
          r_len    <= w_len0;
        end
        for (int k = 1; k < NBYTES; k++)
          if (r_idx == 3'(k)) r_operand[(k-1)*DATA_W +: DATA_W] <= byte_data;
      end
    end
  end
  assign byte_ready = r_state == FETCH;
  assign out_valid  = r_state == HOLD;
  assign busy       = r_state != IDLE;
  assign opcode     = r_opcode;
  assign operand    = r_operand;
  assign instr_len  = r_len;
endmodule

// File: tb/tb_ir_seq.sv
// tb_ir_seq: checks a fixed 2-byte and a variable-length 4-byte instance
// driven by shared inputs, against explicit vectors and a byte-list model.
module tb_ir_seq;
  logic clk = 0, rst_n = 0, flush = 0, start = 0, byte_valid = 0, out_ready = 0;
  logic [7:0] byte_data = 0;
  logic a_rdy, a_val, a_busy, b_rdy, b_val, b_busy;
  logic [7:0] a_op, a_oper, b_op;
  logic [23:0] b_oper;
  logic [2:0] a_len, b_len;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  ir_seq #(.DATA_W(8), .NBYTES(2), .LEN_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(a_rdy), .out_valid(a_val), .out_ready(out_ready),
    .opcode(a_op), .operand(a_oper), .instr_len(a_len), .busy(a_busy));
  ir_seq #(.DATA_W(8), .NBYTES(4), .LEN_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(b_rdy), .out_valid(b_val), .out_ready(out_ready),
    .opcode(b_op), .operand(b_oper), .instr_len(b_len), .busy(b_busy));

  // Model: per instance, a phase (0 idle, 1 collecting, 2 complete) and the byte list so far
  int mph[2];
  int mcnt[2];
  logic [7:0] mb[2][4];

  function automatic int nbytes(input int d);
    return d == 0 ? 2 : 4;
  endfunction
  function automatic int lenf(input int d);
    int l;
    if (d == 0) return 2;
    l = int'(mb[d][0][1:0]) + 1;
    return l > nbytes(d) ? nbytes(d) : l;
  endfunction
  function automatic logic [23:0] exp_oper(input int d);
    logic [23:0] r = 0;
    for (int k = 1; k < mcnt[d]; k++) r = r | (24'(mb[d][k]) << (8*(k-1)));
    return r;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input logic s, bv, input logic [7:0] dat, input logic ordy, fl, rn);
    if (!rn || fl) begin
      mph[d] = 0; mcnt[d] = 0;
    end else if (mph[d] == 0) begin
      if (s) begin mph[d] = 1; mcnt[d] = 0; end
    end else if (mph[d] == 1) begin
      if (bv) begin
        mb[d][mcnt[d]] = dat;
        mcnt[d]++;
        if (mcnt[d] == lenf(d)) mph[d] = 2;
      end
    end else if (ordy) begin
      mph[d] = s ? 1 : 0;
      if (s) mcnt[d] = 0;
    end
  endtask

  task automatic model_cmp();
    int ln;
    ln = mcnt[0] > 0 ? lenf(0) : 2;
    chk("A.byte_ready", a_rdy, mph[0] == 1);
    chk("A.out_valid", a_val, mph[0] == 2);
    chk("A.busy", a_busy, mph[0] != 0);
    chk("A.opcode", a_op, mcnt[0] > 0 ? mb[0][0] : 0);
    chk("A.operand", a_oper, exp_oper(0));
    chk("A.instr_len", a_len, ln);
    ln = mcnt[1] > 0 ? lenf(1) : 4;
    chk("B.byte_ready", b_rdy, mph[1] == 1);
    chk("B.out_valid", b_val, mph[1] == 2);
    chk("B.busy", b_busy, mph[1] != 0);
    chk("B.opcode", b_op, mcnt[1] > 0 ? mb[1][0] : 0);
    chk("B.operand", b_oper, exp_oper(1));
    chk("B.instr_len", b_len, ln);
  endtask

  task automatic step(input logic s, bv, input logic [7:0] dat, input logic ordy, fl, rn);
    start = s; byte_valid = bv; byte_data = dat; out_ready = ordy; flush = fl; rst_n = rn;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_step(d, s, bv, dat, ordy, fl, rn);
    model_cmp();
  endtask

  typedef struct {
    logic s, bv; logic [7:0] d; logic ordy, fl;
    logic e_rdy, e_val; logic [7:0] e_op, e_oper;
  } vec_t;
  vec_t tv[16];

  initial begin
    tv[0]  = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00};
    tv[1]  = '{0, 1, 8'hA5, 0, 0, 1, 0, 8'hA5, 8'h00};
    tv[2]  = '{0, 1, 8'h3C, 0, 0, 0, 1, 8'hA5, 8'h3C};
    for (int i = 3; i < 13; i++) tv[i] = '{logic'(i % 2), 1, 8'(i), 0, 0, 0, 1, 8'hA5, 8'h3C};
    tv[13] = '{1, 0, 8'h00, 1, 0, 1, 0, 8'h00, 8'h00};
    tv[14] = '{0, 1, 8'h77, 0, 1, 0, 0, 8'h00, 8'h00};
    tv[15] = '{0, 1, 8'h88, 0, 0, 0, 0, 8'h00, 8'h00};

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("idle.A.ready", a_rdy, 0); chk("idle.A.valid", a_val, 0);
      chk("idle.A.opcode", a_op, 0); chk("idle.A.operand", a_oper, 0);
      chk("idle.A.len", a_len, 2); chk("idle.B.len", b_len, 4);
    end

    for (int i = 0; i < 16; i++) begin
      step(tv[i].s, tv[i].bv, tv[i].d, tv[i].ordy, tv[i].fl, 1);
      chk($sformatf("vec%0d.ready", i), a_rdy, tv[i].e_rdy);
      chk($sformatf("vec%0d.valid", i), a_val, tv[i].e_val);
      chk($sformatf("vec%0d.opcode", i), a_op, tv[i].e_op);
      chk($sformatf("vec%0d.operand", i), a_oper, tv[i].e_oper);
    end

    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 8'h12, 0, 0, 1);
    chk("var12.len", b_len, 3); chk("var12.opcode", b_op, 8'h12); chk("var12.valid", b_val, 0);
    step(0, 1, 8'hAA, 0, 0, 1);
    step(0, 1, 8'hBB, 0, 0, 1);
    chk("var12.valid_done", b_val, 1); chk("var12.operand", b_oper, 24'h00BBAA);
    chk("var12.ready_hold", b_rdy, 0);
    step(1, 0, 0, 1, 0, 1);
    chk("b2b.ready", b_rdy, 1); chk("b2b.opcode", b_op, 0);
    step(0, 1, 8'h40, 0, 0, 1);
    chk("var40.valid", b_val, 1); chk("var40.operand", b_oper, 0); chk("var40.len", b_len, 1);
    step(1, 0, 0, 1, 0, 1);
    step(0, 1, 8'hF3, 0, 0, 1);
    chk("varF3.opcode", b_op, 8'hF3); chk("varF3.len", b_len, 4);
    step(1, 0, 0, 0, 0, 1);
    chk("stall.ready", b_rdy, 1); chk("stall.opcode", b_op, 8'hF3); chk("stall.operand", b_oper, 0);
    step(0, 0, 8'hEE, 0, 0, 1);
    chk("stall2.operand", b_oper, 0);
    step(0, 1, 8'h11, 0, 0, 1);
    step(0, 1, 8'h22, 0, 0, 1);
    chk("varF3.not_yet", b_val, 0);
    step(0, 1, 8'h33, 0, 0, 1);
    chk("varF3.valid", b_val, 1); chk("varF3.operand", b_oper, 24'h332211);
    step(1, 1, 8'h99, 0, 0, 1);
    chk("hold_start.valid", b_val, 1); chk("hold_start.operand", b_oper, 24'h332211);
    step(1, 0, 0, 1, 0, 1);
    step(0, 1, 8'h12, 0, 0, 1);
    step(0, 1, 8'h55, 0, 1, 1);
    chk("flush.ready", b_rdy, 0); chk("flush.valid", b_val, 0); chk("flush.opcode", b_op, 0);
    step(0, 1, 8'h66, 0, 0, 1);
    chk("flush.after_opcode", b_op, 0); chk("flush.after_valid", b_val, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 8'h40, 0, 0, 1);
    chk("rst_hold.valid_before", b_val, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("rst_hold.valid", b_val, 0); chk("rst_hold.len", b_len, 4);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6, 8'($urandom),
           $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3, $urandom_range(0, 99) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
